// File: rtl/decoder_pkg.sv
// Shared defaults, state encoding and one-hot helper for the pulse decoder.
package decoder_pkg;

    localparam int unsigned IN_W_DEF  = 3;
    localparam int unsigned OUT_W_DEF = 8;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    typedef enum logic {
        StIdle = ST_IDLE,
        StHold = ST_HOLD
    } state_e;

    // Returned 32 bits wide; callers truncate to their own strobe width.
    function automatic logic [31:0] onehot(input int unsigned idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/hold_counter.sv
// Loadable down-counter that stops at zero; paces how long a strobe is held.
module hold_counter #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_value;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/decoder3to8_pulse.sv
// Registered binary-to-one-hot decoder with valid/ready input and HOLD-cycle strobes.
// Optional `STICKY_MASK_EN adds a clearable OR-accumulated mask of every decoded strobe.
module decoder3to8_pulse
    import decoder_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF,
    parameter int unsigned HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in,
    output logic             in_ready,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic             busy
`ifdef STICKY_MASK_EN
    ,
    input  logic             clr,
    output logic [OUT_W-1:0] mask
`endif
);

    localparam int unsigned CW = $clog2(HOLD) + 1;

    state_e           state_q;
    logic [OUT_W-1:0] out_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [CW-1:0]    cnt;
    logic             cnt_zero;
    logic             accept;
    logic [OUT_W-1:0] decoded;

    assign in_ready = (state_q == StIdle) || ((state_q == StHold) && cnt_zero);
    assign accept   = in_valid && in_ready;
    assign decoded  = OUT_W'(onehot(32'(in)));

    hold_counter #(
        .W (CW)
    ) u_hold_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_value (CW'(HOLD - 1)),
        .dec        ((state_q == StHold) && (cnt != '0)),
        .value      (cnt),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q     <= StHold;
                        out_q       <= decoded;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end else begin
                        out_q       <= '0;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                StHold: begin
                    // Last hold cycle: reload back-to-back or fall idle.
                    if (cnt_zero) begin
                        if (accept) begin
                            out_q <= decoded;
                        end else begin
                            state_q     <= StIdle;
                            out_q       <= '0;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

`ifdef STICKY_MASK_EN
    logic [OUT_W-1:0] mask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
        end else if (accept) begin
            mask_q <= (clr ? '0 : mask_q) | decoded;
        end else if (clr) begin
            mask_q <= '0;
        end
    end

    assign mask = mask_q;
`endif

endmodule

// File: tb/tb_decoder3to8_pulse.sv
// Bench for decoder3to8_pulse: HOLD=4 and HOLD=1 instances against a strobe-schedule model.
module tb_decoder3to8_pulse;

    localparam int unsigned NDUT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] in_idx;

    logic       rdy0, ov0, busy0, rdy1, ov1, busy1;
    logic [7:0] out0, out1;

    int checks   = 0;
    int failures = 0;

    // Model: remaining strobe cycles still to show, and the strobe pattern.
    int unsigned hold_of [NDUT] = '{4, 1};
    int unsigned left    [NDUT];
    logic [7:0]  cur     [NDUT];

`ifdef STICKY_MASK_EN
    logic       clr;
    logic [7:0] mask0, mask1;
    logic [7:0] mmask [NDUT];
`endif

    always #5 clk = ~clk;

    decoder3to8_pulse #(.IN_W(3), .OUT_W(8), .HOLD(4)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (in_idx),
        .in_ready  (rdy0),
        .out       (out0),
        .out_valid (ov0),
        .busy      (busy0)
`ifdef STICKY_MASK_EN
        ,
        .clr       (clr),
        .mask      (mask0)
`endif
    );

    decoder3to8_pulse #(.IN_W(3), .OUT_W(8), .HOLD(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (in_idx),
        .in_ready  (rdy1),
        .out       (out1),
        .out_valid (ov1),
        .busy      (busy1)
`ifdef STICKY_MASK_EN
        ,
        .clr       (clr),
        .mask      (mask1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_out(input int i);
        return (left[i] > 0) ? cur[i] : 8'h00;
    endfunction

    task automatic check_all();
        chk("out0",   32'(out0),  32'(exp_out(0)));
        chk("oval0",  32'(ov0),   32'(left[0] > 0));
        chk("busy0",  32'(busy0), 32'(left[0] > 0));
        chk("ready0", 32'(rdy0),  32'(left[0] <= 1));
        chk("out1",   32'(out1),  32'(exp_out(1)));
        chk("oval1",  32'(ov1),   32'(left[1] > 0));
        chk("busy1",  32'(busy1), 32'(left[1] > 0));
        chk("ready1", 32'(rdy1),  32'(left[1] <= 1));
`ifdef STICKY_MASK_EN
        chk("mask0",  32'(mask0), 32'(mmask[0]));
        chk("mask1",  32'(mask1), 32'(mmask[1]));
`endif
    endtask

    // One clock: predict acceptance from current inputs, advance model, check after edge.
    task automatic step();
        bit         acc [NDUT];
        logic [7:0] oh;
        oh = 8'd1 << in_idx;
        for (int i = 0; i < NDUT; i++) acc[i] = in_valid && (left[i] <= 1);
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) begin
            if (rst) begin
                left[i] = 0;
                cur[i]  = 8'h00;
`ifdef STICKY_MASK_EN
                mmask[i] = 8'h00;
`endif
            end else begin
                if (acc[i]) begin
                    cur[i]  = oh;
                    left[i] = hold_of[i];
                end else if (left[i] > 0) begin
                    left[i] = left[i] - 1;
                end
`ifdef STICKY_MASK_EN
                if (acc[i]) mmask[i] = (clr ? 8'h00 : mmask[i]) | oh;
                else if (clr) mmask[i] = 8'h00;
`endif
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            left[i] = 0;
            cur[i]  = 8'h00;
`ifdef STICKY_MASK_EN
            mmask[i] = 8'h00;
`endif
        end
`ifdef STICKY_MASK_EN
        clr = 1'b0;
`endif
        // Reset held two cycles with a valid index present.
        rst = 1'b1; in_valid = 1'b1; in_idx = 3'd5;
        step(); step();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("ready0_after_rst", 32'(rdy0), 32'd1);
        chk("out0_after_rst",   32'(out0), 32'd0);
        step();

        // Single accept of 3 with HOLD=4.
        in_valid = 1'b1; in_idx = 3'd3;
        step();
        in_valid = 1'b0;
        chk("out0_idx3", 32'(out0), 32'h08);
        repeat (5) step();

        // Back-to-back 0 then 7, valid held high.
        in_valid = 1'b1; in_idx = 3'd0;
        step();
        in_idx = 3'd7;
        repeat (3) step();
        chk("out0_idx0_last", 32'(out0), 32'h01);
        step();
        chk("out0_idx7_nogap", 32'(out0), 32'h80);
        in_valid = 1'b0;
        repeat (5) step();

        // Full-rate sweep on the HOLD=1 instance.
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_idx = 3'(k);
            step();
            chk("sweep_out1",   32'(out1), 32'd1 << k);
            chk("sweep_ready1", 32'(rdy1), 32'd1);
        end
        in_valid = 1'b0;
        repeat (5) step();

        // Reset in the middle of a hold.
        in_valid = 1'b1; in_idx = 3'd6;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("midrst_out0",  32'(out0),  32'd0);
        chk("midrst_busy0", 32'(busy0), 32'd0);
        rst = 1'b0;
        step();

`ifdef STICKY_MASK_EN
        in_valid = 1'b1; in_idx = 3'd1;
        step();
        in_idx = 3'd4;
        repeat (8) step();
        in_valid = 1'b0;
        repeat (5) step();
        chk("mask0_sticky", 32'(mask0), 32'h12);
        clr = 1'b1; in_valid = 1'b1; in_idx = 3'd2;
        step();
        chk("mask0_clr_set", 32'(mask0), 32'h04);
        in_valid = 1'b0;
        step();
        chk("mask0_clr", 32'(mask0), 32'h00);
        clr = 1'b0;
        repeat (4) step();
`endif

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(3) != 0);
            in_idx   = 3'($urandom_range(7));
            rst      = ($urandom_range(39) == 0);
`ifdef STICKY_MASK_EN
            clr      = ($urandom_range(15) == 0);
`endif
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
